// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_DM_RUN = 4;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Owner selection between fetch and data ports, with a starvation counter
// that forces a fetch grant after MAX_DM_RUN data wins while fetch waits.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_RUN = DEF_MAX_DM_RUN
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   grant,
    output owner_t owner
);

    localparam int CNT_W = $clog2(MAX_DM_RUN + 1);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic             starved;

    assign starved = (starve_cnt_reg == CNT_W'(MAX_DM_RUN));

    // Data port wins by default (older instruction) unless fetch is starved.
    always_comb begin
        owner = OWN_IF;
        if (dm_req && !(if_req && starved)) begin
            owner = OWN_DM;
        end
    end

    // Count data grants made over a waiting fetch; any fetch grant clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (grant) begin
            if (owner == OWN_IF) begin
                starve_cnt_reg <= '0;
            end else if (if_req && !starved) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises fetch and load/store requests onto
// one memory port, returns registered data with a one-cycle ack, and aborts
// accesses the memory never acknowledges.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_DM_RUN = DEF_MAX_DM_RUN,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t            state_reg;
    owner_t            owner_reg;
    owner_t            sel_owner;
    logic [WD_W-1:0]   wd_cnt_reg;
    logic              grant;
    logic              wd_expired;
    logic [DATA_W-1:0] rsp_data;

    // Arbitrate only in IDLE; RESP deliberately ignores requests so the
    // requester has a cycle to drop req after its ack.
    assign grant      = (state_reg == IDLE) && (if_req_i || dm_req_i);
    assign wd_expired = (wd_cnt_reg == WD_W'(TIMEOUT - 1));
    // Stores and aborts return zero; loads return the memory word.
    assign rsp_data   = (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;

    mem_arb_prio #(
        .MAX_DM_RUN(MAX_DM_RUN)
    ) u_prio (
        .clk   (clk_i),
        .rst_n (rst_i),
        .if_req(if_req_i),
        .dm_req(dm_req_i),
        .grant (grant),
        .owner (sel_owner)
    );

    // Main FSM with registered outputs: latch payload, wait for memory or
    // watchdog, then pulse the owner's ack for exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_IF;
            wd_cnt_reg  <= '0;
            if_ack_o    <= 1'b0;
            if_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            dm_rdata_o  <= '0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            err_o    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        owner_reg  <= sel_owner;
                        wd_cnt_reg <= '0;
                        mem_req_o  <= 1'b1;
                        state_reg  <= ISSUE;
                        if (sel_owner == OWN_DM) begin
                            mem_we_o    <= dm_we_i;
                            mem_addr_o  <= dm_addr_i;
                            mem_wdata_o <= dm_wdata_i;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ack_i || wd_expired) begin
                        mem_req_o <= 1'b0;
                        err_o     <= !mem_ack_i;
                        state_reg <= RESP;
                        if (owner_reg == OWN_DM) begin
                            dm_ack_o   <= 1'b1;
                            dm_rdata_o <= rsp_data;
                        end else begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= rsp_data;
                        end
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
